ising_energy_stream: RTL

Streaming Ising-energy engine that computes E = σᵀ·J·σ for a spin vector σ ∈ {−1,+1}^N. J is delivered as a sequence of column-chunk beats under a valid/ready handshake. It is the parametrised successor of the fixed-chunk MatMul datapath:
- configurable beat width;
- back-pressure-tolerant J input;
- an explicit done/abort protocol;
- a registered "energy lower than previous" flag for the annealing controller.

---
 rtl/ising_energy_stream.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/ising_energy_stream.sv
// Streaming Ising energy engine: accumulates sigma^T * J * sigma over column-chunk beats of J.
// Optional macro MATMUL_DOT_PIPE_EN registers the per-beat contribution and adds a DRAIN state.
module ising_energy_stream #(
  parameter int VECTOR_SIZE     = 256,
  parameter int J_ELEMENT_WIDTH = 4,
  parameter int COLS_PER_BEAT   = 4,
  parameter int NUM_BEATS       = VECTOR_SIZE / COLS_PER_BEAT,
  parameter int ENERGY_WIDTH    = J_ELEMENT_WIDTH + 2 * $clog2(VECTOR_SIZE) + 1
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                start,
  input  logic                                                abort,
  input  logic [VECTOR_SIZE-1:0]                              sigma,
  input  logic signed [ENERGY_WIDTH-1:0]                      energy_prev,
  input  logic                                                j_valid,
  output logic                                                j_ready,
  input  logic [VECTOR_SIZE*COLS_PER_BEAT*J_ELEMENT_WIDTH-1:0] j_data,
  output logic                                                busy,
  output logic                                                done,
  output logic signed [ENERGY_WIDTH-1:0]                      energy,
  output logic                                                lower
);

  // state   | meaning
  // S_IDLE  | waiting for start
  // S_RUN   | accepting J beats
  // S_DRAIN | adding the last registered contribution (pipelined build only)
  // S_DONE  | result published, done high for this cycle
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam int DOT_W = $clog2(VECTOR_SIZE) + J_ELEMENT_WIDTH + 1;
  localparam int BW    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int IW    = $clog2(VECTOR_SIZE);

  state_t                          state;
  logic [VECTOR_SIZE-1:0]          sigma_q;
  logic signed [ENERGY_WIDTH-1:0]  eprev_q;
  logic signed [ENERGY_WIDTH-1:0]  acc;
  logic [BW-1:0]                   beat_cnt;
  logic signed [DOT_W-1:0]         dot [COLS_PER_BEAT];
  logic signed [ENERGY_WIDTH-1:0]  contrib;
  logic signed [ENERGY_WIDTH-1:0]  add_term;
  logic signed [ENERGY_WIDTH-1:0]  sum_next;
  logic [IW-1:0]                   col;
  logic                            accept;
  logic                            last_beat;
`ifdef MATMUL_DOT_PIPE_EN
  logic signed [ENERGY_WIDTH-1:0]  pipe_q;
  logic                            pipe_v;
`endif

  assign accept    = j_valid & j_ready;
  assign last_beat = (beat_cnt == BW'(NUM_BEATS - 1));

  // Each column's dot product is folded back in with the spin of that column's global index.
  always_comb begin
    contrib = '0;
    col     = '0;
    for (int k = 0; k < COLS_PER_BEAT; k++) begin
      dot[k] = '0;
      for (int r = 0; r < VECTOR_SIZE; r++) begin
        if (sigma_q[r])
          dot[k] = dot[k] + DOT_W'(j_data[(k*VECTOR_SIZE+r)*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH]);
        else
          dot[k] = dot[k] - DOT_W'(j_data[(k*VECTOR_SIZE+r)*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH]);
      end
      col = IW'(int'(beat_cnt) * COLS_PER_BEAT + k);
      if (sigma_q[col])
        contrib = contrib + ENERGY_WIDTH'(dot[k]);
      else
        contrib = contrib - ENERGY_WIDTH'(dot[k]);
    end
  end

`ifdef MATMUL_DOT_PIPE_EN
  assign add_term = pipe_v ? pipe_q : '0;
`else
  assign add_term = contrib;
`endif
  assign sum_next = acc + add_term;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sigma_q  <= '0;
      eprev_q  <= '0;
      acc      <= '0;
      beat_cnt <= '0;
      j_ready  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      energy   <= '0;
      lower    <= 1'b0;
`ifdef MATMUL_DOT_PIPE_EN
      pipe_q   <= '0;
      pipe_v   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            sigma_q  <= sigma;
            eprev_q  <= energy_prev;
            acc      <= '0;
            beat_cnt <= '0;
            j_ready  <= 1'b1;
            busy     <= 1'b1;
            state    <= S_RUN;
`ifdef MATMUL_DOT_PIPE_EN
            pipe_v   <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (abort) begin
            j_ready <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
`ifdef MATMUL_DOT_PIPE_EN
            pipe_v  <= 1'b0;
`endif
          end else begin
`ifdef MATMUL_DOT_PIPE_EN
            acc    <= sum_next;
            pipe_q <= contrib;
            pipe_v <= accept;
            if (accept) begin
              beat_cnt <= beat_cnt + 1'b1;
              if (last_beat) begin
                j_ready <= 1'b0;
                state   <= S_DRAIN;
              end
            end
`else
            if (accept) begin
              acc      <= sum_next;
              beat_cnt <= beat_cnt + 1'b1;
              if (last_beat) begin
                j_ready <= 1'b0;
                done    <= 1'b1;
                energy  <= sum_next;
                lower   <= (sum_next < eprev_q);
                state   <= S_DONE;
              end
            end
`endif
          end
        end
        S_DRAIN: begin
          if (abort) begin
            busy  <= 1'b0;
            state <= S_IDLE;
`ifdef MATMUL_DOT_PIPE_EN
            pipe_v <= 1'b0;
`endif
          end else begin
            acc    <= sum_next;
            done   <= 1'b1;
            energy <= sum_next;
            lower  <= (sum_next < eprev_q);
            state  <= S_DONE;
`ifdef MATMUL_DOT_PIPE_EN
            pipe_v <= 1'b0;
`endif
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
